// File: rtl/mem_arbiter_if.sv
// Bus bundle between the request unit, the arbiter and the single-ported RAM.
// Both the datapath lines and the RAM port live here so the arbiter has one bus port.
interface mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  // Handshake: a request line (imemREN / dmemREN / dmemWEN) is held by the
  // requester until its one-cycle hit pulse; the hit is the only completion
  // signal, and iload/dload are meaningful only in that hit cycle.
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              dhit;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramstate,
    output ihit, iload, dhit, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramstate,
    input  ihit, iload, dhit, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serializing instruction reads and data reads/writes onto
// one RAM port; latches a sticky error on RAM ERROR or on a wait timeout.
module mem_arbiter #(
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output logic          mem_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam int         CW         = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              last_d, last_d_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [WORD_W-1:0] data_q, data_nx;
  logic              wr_q, wr_nx;

  logic dreq;
  logic grant_d;
  logic grant_i;
  logic access;
  logic ram_fail;
  logic dreq_held;

  assign dreq      = bus.dmemREN | bus.dmemWEN;
  // On contention the side that did not win last time gets the port.
  assign grant_d   = dreq & (~bus.imemREN | ~last_d);
  assign grant_i   = bus.imemREN & ~grant_d;
  assign access    = (bus.ramstate == RAM_ACCESS);
  assign ram_fail  = (bus.ramstate == RAM_ERROR);
  // A captured write completes only while dmemWEN is still high; a read needs dmemREN.
  assign dreq_held = wr_q ? bus.dmemWEN : bus.dmemREN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last_d <= last_d_nx;
      addr_q <= addr_nx;
      data_q <= data_nx;
      wr_q   <= wr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_d_nx    = last_d;
    addr_nx      = addr_q;
    data_nx      = data_q;
    wr_nx        = wr_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ihit     = 1'b0;
    bus.iload    = '0;
    bus.dhit     = 1'b0;
    bus.dload    = '0;
    mem_err      = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx  = DGNT;
          addr_nx   = bus.dmemaddr;
          data_nx   = bus.dmemstore;
          wr_nx     = bus.dmemWEN;
          last_d_nx = 1'b1;
          cnt_nx    = '0;
        end else if (grant_i) begin
          state_nx  = IGNT;
          addr_nx   = bus.imemaddr;
          wr_nx     = 1'b0;
          last_d_nx = 1'b0;
          cnt_nx    = '0;
        end
      end

      IGNT, DGNT: begin
        bus.ramaddr = addr_q;
        if (state == IGNT) begin
          bus.ramREN = 1'b1;
        end else begin
          bus.ramREN   = ~wr_q;
          bus.ramWEN   = wr_q;
          bus.ramstore = data_q;
        end

        if (access) begin
          state_nx = IDLE;
          if (state == IGNT && bus.imemREN) begin
            bus.ihit  = 1'b1;
            bus.iload = bus.ramload;
          end
          if (state == DGNT && dreq_held) begin
            bus.dhit  = 1'b1;
            bus.dload = bus.ramload;
          end
        end else if (ram_fail) begin
          state_nx = ERR;
        end else begin
          if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
          // This waiting cycle is the MAX_WAIT-th one: give up on the RAM.
          if (cnt >= CNT_LAST) state_nx = ERR;
        end
      end

      ERR: begin
        mem_err = 1'b1;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  hits_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.ihit && bus.dhit));

  no_enables_outside_grant: assert property (@(posedge CLK) disable iff (!nRST)
    (state == IDLE || state == ERR) |-> !(bus.ramREN || bus.ramWEN));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic       CLK;
  logic       nRST;
  logic       mem_err;
  logic [1:0] dbg_state;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .mem_err   (mem_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  // Addresses of accesses the model has granted and not yet retired.
  logic [ADDR_W-1:0] exp_q[$];

  int                m_owner;       // 0 nobody, 1 instruction, 2 data
  bit                m_dead;
  bit                m_last_data;
  bit                m_write;
  logic [WORD_W-1:0] m_store;
  int                m_waited;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner     = 0;
    m_dead      = 1'b0;
    m_last_data = 1'b0;
    m_write     = 1'b0;
    m_store     = '0;
    m_waited    = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic i_r, input logic [31:0] i_a,
                            input logic d_r, input logic d_w,
                            input logic [31:0] d_a, input logic [31:0] d_s,
                            input logic [1:0] rs);
    bit want_d;
    want_d = d_r | d_w;
    if (m_dead) return;
    if (m_owner != 0) begin
      if (rs == RS_ACCESS) begin
        m_owner = 0;
        void'(exp_q.pop_front());
      end else if (rs == RS_ERROR) begin
        m_dead = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= MAX_WAIT) m_dead = 1'b1;
      end
    end else if (want_d && (!i_r || !m_last_data)) begin
      m_owner     = 2;
      m_write     = d_w;
      m_store     = d_s;
      m_last_data = 1'b1;
      m_waited    = 0;
      exp_q.push_back(d_a);
    end else if (i_r) begin
      m_owner     = 1;
      m_write     = 1'b0;
      m_last_data = 1'b0;
      m_waited    = 0;
      exp_q.push_back(i_a);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic i_r, input logic [31:0] i_a,
                       input logic d_r, input logic d_w,
                       input logic [31:0] d_a, input logic [31:0] d_s,
                       input logic [1:0] rs, input logic [31:0] rl);
    bus.imemREN   = i_r;
    bus.imemaddr  = i_a;
    bus.dmemREN   = d_r;
    bus.dmemWEN   = d_w;
    bus.dmemaddr  = d_a;
    bus.dmemstore = d_s;
    bus.ramstate  = rs;
    bus.ramload   = rl;
  endtask

  // One clock cycle: drive at the falling edge, compare just after, advance model at the rising edge.
  task automatic step(input logic i_r, input logic [31:0] i_a,
                      input logic d_r, input logic d_w,
                      input logic [31:0] d_a, input logic [31:0] d_s,
                      input logic [1:0] rs, input logic [31:0] rl);
    logic [31:0] e_ren, e_wen, e_addr, e_store, e_ihit, e_iload, e_dhit, e_dload, e_err;
    logic        held;
    @(negedge CLK);
    drive(i_r, i_a, d_r, d_w, d_a, d_s, rs, rl);
    #1;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    e_ihit = 0; e_iload = 0; e_dhit = 0; e_dload = 0; e_err = 0;
    if (m_dead) begin
      e_err = 1;
    end else if (m_owner == 1) begin
      e_ren  = 1;
      e_addr = exp_q[0];
      if (rs == RS_ACCESS && i_r) begin
        e_ihit  = 1;
        e_iload = rl;
      end
    end else if (m_owner == 2) begin
      e_ren   = m_write ? 0 : 1;
      e_wen   = m_write ? 1 : 0;
      e_addr  = exp_q[0];
      e_store = m_store;
      held    = m_write ? d_w : d_r;
      if (rs == RS_ACCESS && held) begin
        e_dhit  = 1;
        e_dload = rl;
      end
    end
    check("ramREN",   32'(bus.ramREN),   e_ren);
    check("ramWEN",   32'(bus.ramWEN),   e_wen);
    check("ramaddr",  bus.ramaddr,       e_addr);
    check("ramstore", bus.ramstore,      e_store);
    check("ihit",     32'(bus.ihit),     e_ihit);
    check("iload",    bus.iload,         e_iload);
    check("dhit",     32'(bus.dhit),     e_dhit);
    check("dload",    bus.dload,         e_dload);
    check("mem_err",  32'(mem_err),      e_err);
    check("hit_excl", 32'(bus.ihit & bus.dhit), 32'd0);
    @(posedge CLK);
    model_edge(i_r, i_a, d_r, d_w, d_a, d_s, rs);
  endtask

  // Called just after a falling edge: asserts reset mid-cycle, checks the
  // asynchronous drop, then releases on a later falling edge.
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    #1;
    check("rst_ramREN",  32'(bus.ramREN), 32'd0);
    check("rst_ramWEN",  32'(bus.ramWEN), 32'd0);
    check("rst_ihit",    32'(bus.ihit),   32'd0);
    check("rst_dhit",    32'(bus.dhit),   32'd0);
    check("rst_mem_err", 32'(mem_err),    32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, RS_FREE, '0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dead_cycles;
    logic [1:0] rs;
    int r;

    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, RS_FREE, '0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("init_state",   32'(dbg_state),   32'd0);
    check("init_ramaddr", bus.ramaddr,      32'd0);
    check("init_mem_err", 32'(mem_err),     32'd0);

    // Single instruction read: BUSY twice, then ACCESS.
    step(1, 32'h40, 0, 0, 0, 0, RS_FREE,   32'h0);
    step(1, 32'h40, 0, 0, 0, 0, RS_BUSY,   32'h0);
    step(1, 32'h40, 0, 0, 0, 0, RS_BUSY,   32'h0);
    step(1, 32'h40, 0, 0, 0, 0, RS_ACCESS, 32'h0011_8093);
    step(0, 32'h40, 0, 0, 0, 0, RS_FREE,   32'h0);

    // Contention with both requests held: D,I,D,I.
    @(negedge CLK); do_reset();
    for (int c = 0; c < 8; c++)
      step(1, 32'h80 + 32'(c), 1, 0, 32'h1000 + 32'(c), 32'h0, RS_ACCESS, 32'hA000 + 32'(c));

    // Write priority; address changes during BUSY must not reach the RAM.
    @(negedge CLK); do_reset();
    step(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, RS_FREE,   0);
    step(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, RS_BUSY,   0);
    step(0, 0, 1, 1, 32'h200, 32'h1234_5678, RS_BUSY,   0);
    step(0, 0, 1, 1, 32'h200, 32'h1234_5678, RS_ACCESS, 32'h5555_5555);
    step(0, 0, 0, 0, 32'h200, 32'h0,         RS_FREE,   0);

    // Dropped read: access completes silently.
    @(negedge CLK); do_reset();
    step(0, 0, 1, 0, 32'h300, 0, RS_FREE,   0);
    step(0, 0, 1, 0, 32'h300, 0, RS_BUSY,   0);
    step(0, 0, 0, 0, 32'h300, 0, RS_BUSY,   0);
    step(0, 0, 0, 0, 32'h300, 0, RS_ACCESS, 32'hCAFE_F00D);
    step(0, 0, 0, 0, 32'h300, 0, RS_FREE,   0);
    check("drop_idle", 32'(dbg_state), 32'd0);

    // Timeout: RAM stuck BUSY, then requests are ignored.
    @(negedge CLK); do_reset();
    step(0, 0, 1, 0, 32'h400, 0, RS_FREE, 0);
    for (int c = 0; c < MAX_WAIT + 4; c++)
      step(0, 0, 1, 0, 32'h400, 0, RS_BUSY, 0);
    for (int c = 0; c < 4; c++)
      step(1, 32'h44, 1, c[0], 32'h500, 32'h77, RS_ACCESS, 32'h99);

    // RAM ERROR status: error on the next edge.
    @(negedge CLK); do_reset();
    step(1, 32'h48, 0, 0, 0, 0, RS_FREE,   0);
    step(1, 32'h48, 0, 0, 0, 0, RS_ERROR,  0);
    step(1, 32'h48, 0, 0, 0, 0, RS_ACCESS, 32'h1);
    step(1, 32'h48, 1, 0, 0, 0, RS_ACCESS, 32'h2);

    // Asynchronous reset in the middle of a data grant with ACCESS pending.
    @(negedge CLK); do_reset();
    step(0, 0, 1, 0, 32'h600, 0, RS_FREE, 0);
    @(negedge CLK);
    drive(1'b0, '0, 1'b1, 1'b0, 32'h600, '0, RS_ACCESS, 32'h1357_9BDF);
    #1;
    check("pre_rst_dhit",   32'(bus.dhit),   32'd1);
    check("pre_rst_ramREN", 32'(bus.ramREN), 32'd1);
    do_reset();

    // Randomized traffic; recover from error by resetting.
    dead_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 127);
      if (r == 0)       rs = RS_ERROR;
      else if (r < 45)  rs = RS_BUSY;
      else if (r < 60)  rs = RS_FREE;
      else              rs = RS_ACCESS;
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           $urandom, $urandom, rs, $urandom);
      if (m_dead) dead_cycles++;
      if (dead_cycles > 3) begin
        dead_cycles = 0;
        @(negedge CLK); do_reset();
      end
    end

    check("queue_depth", 32'(exp_q.size() <= 1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit, between the datapath's instruction/data request lines and the single-ported RAM.
- Serializes imemREN and dmemREN/dmemWEN onto one RAM port.
- Returns read data plus one-cycle ihit/dhit pulses, which feed the request unit's ihit/dhit inputs.
- Round-robin on contention; latches a sticky error on RAM ERROR or wait timeout.

Parameters:
- WORD_W, 32, data width of load/store paths.
- ADDR_W, 32, address width.
- MAX_WAIT, 15, max cycles a granted access may wait for ACCESS before timeout; must be ≥1.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  input  1  instruction read request.
- imemaddr  input  ADDR_W  instruction address.
- dmemREN  input  1  data read request.
- dmemWEN  input  1  data write request.
- dmemaddr  input  ADDR_W  data address.
- dmemstore  input  WORD_W  write data.
- ihit  output  1  instruction access complete (1-cycle pulse).
- iload  output  WORD_W  instruction word, valid when ihit=1.
- dhit  output  1  data access complete (1-cycle pulse).
- dload  output  WORD_W  load data, valid when dhit=1.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- mem_err  output  1  sticky error flag.

Behaviour:
- FSM states: IDLE, IGNT, DGNT, ERR.
- Reset (async, nRST=0):
  - State IDLE, wait counter 0, last_grant=INSTR, captured addr/data 0.
  - All outputs 0.
  - Reset mid-access abandons the access immediately; RAM enables drop asynchronously.
- IDLE:
  - Data request = dmemREN|dmemWEN.
  - Only data pending → DGNT. Only imemREN pending → IGNT.
  - Both pending → grant opposite of last_grant, i.e. data if last_grant=INSTR, else instruction.
  - On grant: capture addr (and dmemstore, plus write-vs-read, for data) into registers; set last_grant; clear counter.
  - No RAM enables driven in IDLE.
- Write priority: dmemREN and dmemWEN both high → treated as a write.
- IGNT/DGNT:
  - ramREN/ramWEN/ramaddr/ramstore are driven from the captured registers, stable for the whole access.
  - Counter increments each cycle that ramstate≠ACCESS.
- Completion (ramstate=ACCESS):
  - Same cycle: assert ihit (IGNT) or dhit (DGNT) combinationally, only if the originating request is still asserted.
  - iload/dload = ramload while hit=1, else 0.
  - Next state IDLE.
  - Request dropped before ACCESS: the RAM access still completes, the hit is suppressed, and the data is discarded.
- Latency:
  - Request seen in IDLE at cycle 0 → RAM enable from cycle 1 → hit in first cycle with ACCESS (≥ cycle 1).
  - One IDLE cycle between consecutive grants.
- Error:
  - ramstate=ERROR in IGNT/DGNT, or counter reaching MAX_WAIT → ERR.
  - In ERR: mem_err=1, all RAM enables 0, no hits, all requests ignored.
  - Only nRST exits ERR.
- Counter: width ceil(log2(MAX_WAIT+1)); saturating, never wraps.
- ihit and dhit are never high in the same cycle.

Test Plan:
- Reset: nRST=0 async mid-cycle during DGNT → ramREN/ramWEN/dhit/mem_err=0 immediately; state IDLE after release.
- Single read: imemREN=1, imemaddr=0x0000_0040, ramstate BUSY 2 cycles then ACCESS with ramload=0x0011_8093 → ramREN=1 from cycle 1, ihit=1 and iload=0x0011_8093 in cycle 3 only.
- Contention fairness: imemREN and dmemREN held high, ramstate always ACCESS → grants alternate D,I,D,I; dhit in cycles 1,5; ihit in cycles 3,7.
- Write priority and stability: dmemREN=dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEAD_BEEF; change dmemaddr to 0x200 during BUSY → ramWEN=1, ramREN=0, ramaddr stays 0x100 until ACCESS; dhit=1.
- Dropped request: dmemREN deasserted while BUSY, then ACCESS → dhit stays 0 and dload=0; FSM returns to IDLE.
- Errors:
  - ramstate stuck BUSY with MAX_WAIT=15 → ERR after 15 granted cycles; mem_err=1 held; later requests produce no RAM enables.
  - Separately, ramstate=11 → ERR on the next edge.
